ram_dp_be: RTL and testbench
============================

Name: ram_dp_be

Overview:
Parametrised simple dual-port synchronous RAM, successor to the 64x8 single-clock RAM. Adds byte-enable writes, selectable read latency (1 or 2 cycles), a selectable read-during-write mode, a read-valid output and address range checking. Memory is cleared by a post-reset init sequencer that writes one word per cycle, so the array maps to block RAM without a reset loop. Sits between bus adapters and datapath blocks as the team's generic scratch/buffer memory.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 6, address width in bits
DEPTH, 48, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2 only
RDW_MODE, 0, same-address read-during-write: 0 returns old data, 1 returns new (merged) data

Ports:
clk  in  1  clock, all logic on the rising edge
rstn  in  1  reset, synchronous, active-low
wr_enb  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  DATA_WIDTH/8  byte enables; bit k enables wr_data[8k+7:8k]
wr_data  in  DATA_WIDTH  write data
rd_enb  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data; holds its value between reads
rd_valid  out  1  one-cycle pulse marking rd_data for one accepted read
init_done  out  1  high once the memory clear has finished; accesses accepted only when high
addr_err  out  1  one-cycle pulse: an accepted request had address >= DEPTH

Behaviour:
- Reset (rstn=0 at an edge): state<=INIT, clr_cnt<=0. Outputs: rd_data=0, rd_valid=0, init_done=0, addr_err=0. Read pipeline stages are cleared. Memory contents are not touched during reset.
- FSM INIT: each cycle writes mem[clr_cnt]<=0 and increments clr_cnt. When clr_cnt==DEPTH-1 the FSM moves to READY. init_done is registered high on that same edge, so it rises exactly DEPTH cycles after the first edge with rstn=1.
- FSM READY: terminal state. Left only by reset. Reset asserted mid-INIT or in READY restarts the clear from 0.
- While init_done=0: wr_enb and rd_enb are ignored. No memory update, no rd_valid, no addr_err.
- Write is accepted when init_done & wr_enb & wr_addr<DEPTH. For each k with wr_be[k]=1, byte k of mem[wr_addr] takes the corresponding byte of wr_data. Other bytes are unchanged. wr_be=0 is a legal no-op write.
- Read is accepted when init_done & rd_enb:
  - RD_LATENCY=1: rd_data and rd_valid update on the same edge that samples rd_enb.
  - RD_LATENCY=2: they update one edge later.
  - Back-to-back reads every cycle give full throughput, with rd_valid high continuously.
- Read with rd_addr>=DEPTH: returns rd_data=0 with rd_valid=1.
- Address error: any accepted read or write with address>=DEPTH raises addr_err for one cycle on the sampling edge, independent of RD_LATENCY. Read and write errors in the same cycle give a single pulse. An out-of-range write leaves memory unchanged.
- Read-during-write, same in-range address, same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (enabled bytes from wr_data, other bytes from the old word).
  - Different addresses never interact.
- rd_data keeps its last value when no read completes. rd_valid is 0 in that case.
- Illegal parameters (DATA_WIDTH%8!=0, DEPTH>2**ADDR_WIDTH, RD_LATENCY not 1 or 2, RDW_MODE not 0 or 1) are rejected by an elaboration-time check.

Test Plan:
1. Init: release rstn, hold rd_enb=1 at addr 0 -> init_done rises exactly 48 cycles later, no rd_valid before it, first read returns 0x00000000 with rd_valid=1.
2. Byte enable: write 0xAABBCCDD with be=4'hF to addr 5, then 0x11223344 with be=4'b0101 to addr 5, read addr 5 -> 0xAA22CC44.
3. Latency: RD_LATENCY=1, then 2, reads of addrs 1,2,3 on consecutive cycles -> rd_valid high for 3 consecutive cycles starting 1 or 2 edges after the first request, data in request order.
4. RDW: addr 7 holds 0x01020304, same-cycle write 0xFFFFFFFF be=4'b0011 and read of addr 7 -> RDW_MODE=0 returns 0x01020304, RDW_MODE=1 returns 0x0102FFFF, later read returns 0x0102FFFF in both modes.
5. Range: write addr 50 (DEPTH=48) -> addr_err pulse, no memory change. Read addr 63 -> rd_data=0, rd_valid=1, addr_err=1.
6. Reset mid-op: write addr 3 = 0x5A5A5A5A, assert rstn=0 for 1 cycle during INIT cycle 10 of a second init -> init_done stays low for 48 more cycles, then addr 3 reads 0.

Source files
------------

// File: rtl/ram_dp_be.sv
// ram_dp_be: simple dual-port RAM with byte enables, 1/2-cycle read latency and post-reset clear
module ram_dp_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 48,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_enb,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_enb,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_done,
    output logic                    addr_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % 8 != 0 || DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH) ||
        !(RD_LATENCY == 1 || RD_LATENCY == 2) || !(RDW_MODE == 0 || RDW_MODE == 1)) begin : g_bad_param
        $error("ram_dp_be: illegal parameter set");
    end

    typedef enum logic {INIT, READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
    logic                    init_done_q, init_done_d;
    logic                    addr_err_q, addr_err_d;
    logic                    p_valid_q, p_valid_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_req, rd_req, wr_in, rd_in, wr_acc, clr_wr, src_valid;
    logic [DATA_WIDTH-1:0]   rd_word, src_data;

    // request qualification: nothing is accepted before the clear finishes or during reset
    always_comb begin
        wr_req = rstn & init_done_q & wr_enb;
        rd_req = rstn & init_done_q & rd_enb;
        wr_in  = {1'b0, wr_addr} < DEPTH_W;
        rd_in  = {1'b0, rd_addr} < DEPTH_W;
        wr_acc = wr_req & wr_in;
        clr_wr = rstn & (state_q == INIT);
    end

    // memory array: init clear or byte-enabled write, no reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_q] <= '0;
        end else if (wr_acc) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // read word: out-of-range reads return zero, optional bypass of same-address write bytes
    always_comb begin
        rd_word = rd_in ? mem[rd_addr] : '0;
        if (RDW_MODE == 1 && wr_acc && wr_addr == rd_addr) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) rd_word[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // next-state: clear sequencer, error pulse and read pipeline
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        if (state_q == INIT) begin
            clr_d = clr_q + ADDR_WIDTH'(1);
            if (clr_q == LAST) state_d = READY;
        end
        init_done_d = (state_d == READY);
        addr_err_d  = (wr_req & ~wr_in) | (rd_req & ~rd_in);
        p_valid_d   = rd_req;
        p_data_d    = rd_req ? rd_word : p_data_q;
        src_valid   = (RD_LATENCY == 2) ? p_valid_q : rd_req;
        src_data    = (RD_LATENCY == 2) ? p_data_q : rd_word;
        rd_valid_d  = src_valid;
        rd_data_d   = src_valid ? src_data : rd_data_q;
    end

    // control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= INIT;
            clr_q       <= '0;
            init_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            p_valid_q   <= 1'b0;
            p_data_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            init_done_q <= init_done_d;
            addr_err_q  <= addr_err_d;
            p_valid_q   <= p_valid_d;
            p_data_q    <= p_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = init_done_q;
    assign addr_err  = addr_err_q;
endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: random and directed checks of two RAM configurations against an array model
module tb_ram_dp_be;
    localparam int DEPTH = 48;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_enb = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_enb = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, init_done0, init_done1, addr_err0, addr_err1;

    int total = 0;
    int bad = 0;

    logic [31:0] mem_m [64];
    int          cnt = 0;
    logic        v0 = 1'b0, v1 = 1'b0, pv = 1'b0, err = 1'b0;
    logic [31:0] d0 = '0, d1 = '0, pd = '0;

    ram_dp_be #(.RD_LATENCY(1), .RDW_MODE(0)) u0 (
        .clk(clk), .rstn(rstn), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .init_done(init_done0), .addr_err(addr_err0)
    );

    ram_dp_be #(.RD_LATENCY(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rstn(rstn), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .init_done(init_done1), .addr_err(addr_err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // one clock of stimulus, model update and full output comparison for both instances
    task automatic cyc(input logic we, input logic [5:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [5:0] ra);
        logic [31:0] old, mrg;
        logic wacc, racc, done;
        wr_enb = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_enb = re; rd_addr = ra;
        done = (cnt >= DEPTH);
        racc = rstn && done && re;
        wacc = rstn && done && we;
        old = (int'(ra) < DEPTH) ? mem_m[ra] : 32'h0;
        mrg = old;
        if (wacc && wa == ra && int'(ra) < DEPTH)
            for (int b = 0; b < 4; b++) if (be[b]) mrg[8*b +: 8] = wd[8*b +: 8];
        @(posedge clk);
        #1;
        if (!rstn) begin
            cnt = 0; v0 = 0; d0 = 0; v1 = 0; d1 = 0; pv = 0; pd = 0; err = 0;
        end else begin
            v0 = racc;
            if (racc) d0 = old;
            v1 = pv;
            if (pv) d1 = pd;
            pv = racc;
            pd = mrg;
            err = (racc && int'(ra) >= DEPTH) || (wacc && int'(wa) >= DEPTH);
            if (wacc && int'(wa) < DEPTH)
                for (int b = 0; b < 4; b++) if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
            if (cnt < DEPTH) begin
                cnt++;
                if (cnt == DEPTH) for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
            end
        end
        chk("data0", rd_data0, d0);
        chk("valid0", 32'(rd_valid0), 32'(v0));
        chk("err0", 32'(addr_err0), 32'(err));
        chk("done0", 32'(init_done0), 32'(cnt >= DEPTH));
        chk("data1", rd_data1, d1);
        chk("valid1", 32'(rd_valid1), 32'(v1));
        chk("err1", 32'(addr_err1), 32'(err));
        chk("done1", 32'(init_done1), 32'(cnt >= DEPTH));
    endtask

    task automatic idle();
        cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0);
    endtask

    function automatic logic [5:0] rnd_addr();
        return ($urandom % 8 == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 47));
    endfunction

    initial begin
        logic        we, re;
        logic [5:0]  wa, ra;
        for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
        rstn = 1'b0;
        idle();
        idle();
        rstn = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd0);
            chk("init_rise", 32'(init_done0), 32'(i == DEPTH));
            chk("no_early_valid", 32'(rd_valid0), 32'h0);
        end
        cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd0);
        chk("first_rd_valid", 32'(rd_valid0), 32'h1);
        chk("first_rd_data", rd_data0, 32'h0);
        idle();

        cyc(1'b1, 6'd5, 4'hF, 32'hAABBCCDD, 1'b0, 6'd0);
        cyc(1'b1, 6'd5, 4'b0101, 32'h11223344, 1'b0, 6'd0);
        cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5);
        chk("be_merge0", rd_data0, 32'hAA22CC44);
        idle();
        chk("be_merge1", rd_data1, 32'hAA22CC44);

        cyc(1'b1, 6'd1, 4'hF, 32'h00000101, 1'b0, 6'd0);
        cyc(1'b1, 6'd2, 4'hF, 32'h00000202, 1'b0, 6'd0);
        cyc(1'b1, 6'd3, 4'hF, 32'h00000303, 1'b0, 6'd0);
        for (int i = 1; i <= 3; i++) cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'(i));
        idle();
        idle();

        cyc(1'b1, 6'd7, 4'hF, 32'h01020304, 1'b0, 6'd0);
        cyc(1'b1, 6'd7, 4'b0011, 32'hFFFFFFFF, 1'b1, 6'd7);
        chk("rdw_old", rd_data0, 32'h01020304);
        idle();
        chk("rdw_new", rd_data1, 32'h0102FFFF);
        cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd7);
        chk("rdw_after0", rd_data0, 32'h0102FFFF);
        idle();
        chk("rdw_after1", rd_data1, 32'h0102FFFF);

        cyc(1'b1, 6'd50, 4'hF, 32'hDEADBEEF, 1'b0, 6'd0);
        chk("wr_oor_err", 32'(addr_err0), 32'h1);
        cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd63);
        chk("rd_oor_err", 32'(addr_err0), 32'h1);
        chk("rd_oor_valid", 32'(rd_valid0), 32'h1);
        chk("rd_oor_data", rd_data0, 32'h0);
        idle();
        chk("rd_oor_data1", rd_data1, 32'h0);

        cyc(1'b1, 6'd3, 4'hF, 32'h5A5A5A5A, 1'b0, 6'd0);
        rstn = 1'b0;
        idle();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) idle();
        rstn = 1'b0;
        idle();
        rstn = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            idle();
            chk("reinit_rise", 32'(init_done1), 32'(i == DEPTH));
        end
        cyc(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd3);
        chk("reinit_clear", rd_data0, 32'h0);
        idle();

        for (int i = 0; i < 500; i++) begin
            we = 1'($urandom);
            re = 1'($urandom);
            wa = rnd_addr();
            ra = ($urandom % 4 == 0) ? wa : rnd_addr();
            cyc(we, wa, 4'($urandom), $urandom, re, ra);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
